memory_stage: RTL

//  M stage of the 19-bit pipeline, directly downstream of Execute.
//  - Consumes Execute's M-register outputs: RegWriteM, MemWriteM, ResultSrcM, RDM, ALUResultM, WriteDataM.
//  - Performs loads/stores on a variable-latency data memory through a req/ready handshake.
//  - Stalls the upstream pipeline while an access is outstanding.
//  - Owns the M/W pipeline register that feeds Writeback.

---
 rtl/memory_stage_if.sv | 19 +
 rtl/memory_stage.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/memory_stage_if.sv
// Data-memory port between the M stage (master) and a variable-latency memory (slave).
`timescale 1ns/1ps
interface memory_stage_if #(
  parameter int DATA_W = 19,
  parameter int MEM_AW = 16
);
  // Handshake: the master raises MemReq with MemWe/MemAddr/MemWData and holds all four
  // stable until a cycle where MemReady=1; that cycle completes the transfer, and for
  // reads MemRData is valid only in that cycle. MemReady without MemReq means nothing.
  logic              MemReq;
  logic              MemWe;
  logic [MEM_AW-1:0] MemAddr;
  logic [DATA_W-1:0] MemWData;
  logic              MemReady;
  logic [DATA_W-1:0] MemRData;

  modport master (output MemReq, MemWe, MemAddr, MemWData, input MemReady, MemRData);
  modport slave  (input MemReq, MemWe, MemAddr, MemWData, output MemReady, MemRData);
endinterface

// File: rtl/memory_stage.sv
// M stage: issues loads/stores on a req/ready memory, stalls upstream while an access is
// outstanding, aborts after TIMEOUT cycles, and owns the M/W pipeline register.
`timescale 1ns/1ps
module memory_stage #(
  parameter int DATA_W  = 19,
  parameter int MEM_AW  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ValidM,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic [1:0]        ResultSrcM,
  input  logic [4:0]        RDM,
  input  logic [DATA_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  memory_stage_if.master    mem,
  output logic              StallM,
  output logic              RegWriteW,
  output logic [1:0]        ResultSrcW,
  output logic [4:0]        RDW,
  output logic [DATA_W-1:0] ALUResultW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic              AddrErr,
  output logic              MemErr,
  output logic              dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              regwrite_w_q, regwrite_w_d;
  logic [1:0]        resultsrc_w_q, resultsrc_w_d;
  logic [4:0]        rd_w_q, rd_w_d;
  logic [DATA_W-1:0] aluresult_w_q, aluresult_w_d;
  logic [DATA_W-1:0] readdata_w_q, readdata_w_d;
  logic              addr_err_q, addr_err_d;
  logic              mem_err_q, mem_err_d;

  logic              memop, bad, stall;
  logic [1:0]        src_norm;

  always_comb begin
    memop    = ValidM & (MemWriteM | (ResultSrcM == 2'b01));
    bad      = memop & (|ALUResultM[DATA_W-1:MEM_AW]);
    // Reserved select codes are passed to Writeback as "ALU result".
    src_norm = ResultSrcM[1] ? 2'b00 : ResultSrcM;

    state_d       = state_q;
    cnt_d         = cnt_q;
    req_d         = req_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    regwrite_w_d  = regwrite_w_q;
    resultsrc_w_d = resultsrc_w_q;
    rd_w_d        = rd_w_q;
    aluresult_w_d = aluresult_w_q;
    readdata_w_d  = readdata_w_q;
    addr_err_d    = addr_err_q;
    mem_err_d     = mem_err_q;
    stall         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (memop && !bad) begin
          stall        = 1'b1;
          regwrite_w_d = 1'b0;
          req_d        = 1'b1;
          we_d         = MemWriteM;
          addr_d       = ALUResultM[MEM_AW-1:0];
          wdata_d      = WriteDataM;
          cnt_d        = '0;
          state_d      = S_ACCESS;
        end else begin
          regwrite_w_d  = RegWriteM & ValidM & ~bad;
          resultsrc_w_d = src_norm;
          rd_w_d        = RDM;
          aluresult_w_d = ALUResultM;
          readdata_w_d  = '0;
          if (bad) addr_err_d = 1'b1;
        end
      end
      S_ACCESS: begin
        if (mem.MemReady || cnt_q == CW'(TIMEOUT - 1)) begin
          // Ready beats the timeout when both land in the same cycle.
          req_d         = 1'b0;
          we_d          = 1'b0;
          addr_d        = '0;
          wdata_d       = '0;
          state_d       = S_IDLE;
          resultsrc_w_d = src_norm;
          rd_w_d        = RDM;
          aluresult_w_d = ALUResultM;
          if (mem.MemReady) begin
            regwrite_w_d = RegWriteM & ValidM;
            readdata_w_d = we_q ? '0 : mem.MemRData;
          end else begin
            regwrite_w_d = 1'b0;
            readdata_w_d = '0;
            mem_err_d    = 1'b1;
          end
        end else begin
          stall        = 1'b1;
          regwrite_w_d = 1'b0;
          cnt_d        = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      regwrite_w_q  <= 1'b0;
      resultsrc_w_q <= 2'b00;
      rd_w_q        <= '0;
      aluresult_w_q <= '0;
      readdata_w_q  <= '0;
      addr_err_q    <= 1'b0;
      mem_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_q         <= req_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      regwrite_w_q  <= regwrite_w_d;
      resultsrc_w_q <= resultsrc_w_d;
      rd_w_q        <= rd_w_d;
      aluresult_w_q <= aluresult_w_d;
      readdata_w_q  <= readdata_w_d;
      addr_err_q    <= addr_err_d;
      mem_err_q     <= mem_err_d;
    end
  end

  // Gated by reset so upstream is released while reset is held, whatever sits in M.
  assign StallM       = reset & stall;
  assign mem.MemReq   = req_q;
  assign mem.MemWe    = we_q;
  assign mem.MemAddr  = addr_q;
  assign mem.MemWData = wdata_q;
  assign RegWriteW    = regwrite_w_q;
  assign ResultSrcW   = resultsrc_w_q;
  assign RDW          = rd_w_q;
  assign ALUResultW   = aluresult_w_q;
  assign ReadDataW    = readdata_w_q;
  assign AddrErr      = addr_err_q;
  assign MemErr       = mem_err_q;
  assign dbg_state    = state_q;

endmodule
